// File: rtl/mdu.sv
// Multiply/divide unit: HI/LO register pair with fixed-latency long operations.
// mult/multu/div/divu latch their operands, stay busy for a fixed number of
// cycles, then write HI/LO and pulse done. mthi/mtlo write at once.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic [2:0]  MDUop,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [0:0]          state;
  logic [3:0]          cnt;
  logic [2:0]          op_p0;
  logic signed [31:0]  a_p0;
  logic signed [31:0]  b_p0;
  logic                accept;
  logic                is_mul;
  logic                is_div;
  logic                finish;
  logic [63:0]         mul_res;
  logic [63:0]         div_res;

  // 64-bit product; signed operands are sign-extended before multiplying.
  function automatic logic [63:0] mul_calc(input logic is_signed,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    bx = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    return ax * bx;
  endfunction

  // Division on magnitudes, then sign fix-up: quotient truncates toward zero,
  // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000 r 0.
  // Returns {remainder, quotient}. A zero divisor is replaced by 1 so the
  // result stays defined; the caller never writes it back in that case.
  function automatic logic [63:0] div_calc(input logic is_signed,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q;
    logic [31:0] r;
    neg_a = is_signed & a[31];
    neg_b = is_signed & b[31];
    mag_a = neg_a ? (32'd0 - a) : a;
    mag_b = neg_b ? (32'd0 - b) : b;
    if (mag_b == 32'd0) mag_b = 32'd1;
    q = mag_a / mag_b;
    r = mag_a % mag_b;
    if (neg_a ^ neg_b) q = 32'd0 - q;
    if (neg_a) r = 32'd0 - r;
    return {r, q};
  endfunction

  assign busy    = (state == RUN);
  assign accept  = start && (state == IDLE);
  assign is_mul  = (MDUop == OP_MULT) || (MDUop == OP_MULTU);
  assign is_div  = (MDUop == OP_DIV) || (MDUop == OP_DIVU);
  assign finish  = (state == RUN) && (cnt == 4'd1);
  assign mul_res = mul_calc(op_p0 == OP_MULT, a_p0, b_p0);
  assign div_res = div_calc(op_p0 == OP_DIV, a_p0, b_p0);

  // Control: IDLE/RUN sequencing, cycle counter and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (accept && (is_mul || is_div)) begin
          state <= RUN;
          cnt   <= is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
        end
      end else begin
        cnt <= cnt - 4'd1;
        if (finish) begin
          state <= IDLE;
          done  <= 1'b1;
        end
      end
    end
  end

  // Operand capture at the accepting edge; held unchanged through RUN.
  always_ff @(posedge clk) begin
    if (accept && (is_mul || is_div)) begin
      op_p0 <= MDUop;
      a_p0  <= srcA;
      b_p0  <= srcB;
    end
  end

  // HI/LO: immediate mthi/mtlo writes, or long-op results on the final edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      HI <= 32'd0;
      LO <= 32'd0;
    end else if (finish) begin
      if ((op_p0 == OP_MULT) || (op_p0 == OP_MULTU)) begin
        HI <= mul_res[63:32];
        LO <= mul_res[31:0];
      end else if (b_p0 != 32'sd0) begin
        HI <= div_res[63:32];
        LO <= div_res[31:0];
      end
    end else if (accept && (MDUop == OP_MTHI)) begin
      HI <= srcA;
    end else if (accept && (MDUop == OP_MTLO)) begin
      LO <= srcA;
    end
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, giving the busy duration of mult/multu in clk cycles (legal range 1..15).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, giving the busy duration of div/divu in clk cycles (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port srcA  input  32  operand A (rs): multiplicand, dividend, or mthi/mtlo data.
REQ-006 SHALL have port srcB  input  32  operand B (rt): multiplier or divisor.
REQ-007 SHALL have port MDUop  input  3  operation code, qualified by start.
REQ-008 SHALL have port start  input  1  operation request, sampled on a rising clk edge.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse after HI/LO are updated by mult/multu/div/divu.
REQ-011 SHALL have port HI  output  32  HI register (mfhi source).
REQ-012 SHALL have port LO  output  32  LO register (mflo source).

Function
REQ-013 SHALL decode MDUop as 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved; both 000 and 111 have no effect.
REQ-014 SHALL treat start as accepted only on an edge where busy=0; start while busy=1 is ignored, with no queuing and no state change.
REQ-015 On accepted mthi/mtlo, SHALL write srcA to HI/LO at that same edge; busy stays 0 and done stays 0.
REQ-016 On accepted mult/multu/div/divu, SHALL latch srcA, srcB and the op at that edge, set busy=1, and load the counter with MULT_CYCLES or DIV_CYCLES.
REQ-017 SHALL have a two-state FSM, IDLE to RUN on an accepted long op; RUN decrements the counter each edge; on the edge where the counter goes 1 to 0, SHALL write HI/LO, set busy=0 and return to IDLE.
REQ-018 SHALL keep busy high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES) after the accepting edge; new HI/LO are visible in the first cycle busy=0.
REQ-019 SHALL assert done for exactly the one cycle following the HI/LO-writing edge.
REQ-020 SHALL hold HI/LO at their previous values throughout RUN.
REQ-021 SHALL compute results only from the latched operands; srcA/srcB changes during RUN have no effect.
REQ-022 For mult, SHALL produce a signed 32x32 to 64-bit product; for multu, an unsigned one; HI = bits 63:32, LO = bits 31:0.
REQ-023 For div, SHALL perform signed division with the quotient truncated toward zero and the remainder taking the dividend's sign; LO = quotient, HI = remainder.
REQ-024 For divu, SHALL perform unsigned division; LO = quotient, HI = remainder.
REQ-025 For div with 0x80000000 / 0xFFFFFFFF, SHALL produce LO=0x80000000, HI=0x00000000.
REQ-026 For div/divu with divisor 0, SHALL leave HI/LO unchanged, still take DIV_CYCLES, and still pulse done.
REQ-027 SHALL accept a new start in the same cycle that done is high, because busy is 0 in that cycle.

Reset
REQ-028 While rst_n=0, SHALL force busy=0, done=0, HI=0, LO=0, counter=0 and FSM=IDLE, asynchronously.
REQ-029 SHALL discard any in-flight operation on reset; no HI/LO write or done pulse may follow deassertion.
REQ-030 After rst_n rises, SHALL accept start from the first rising edge onward.

Verification
REQ-031 SHALL cover: mult with srcA=0xFFFFFFFE (-2), srcB=3 -> busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA, done pulse for 1 cycle.
REQ-032 SHALL cover: multu with srcA=srcB=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-033 SHALL cover: div with srcA=-7 (0xFFFFFFF9), srcB=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; and divu 7/0 -> HI/LO unchanged with done pulsed.
REQ-034 SHALL cover: mthi with srcA=0x12345678 while IDLE -> HI=0x12345678 next cycle and busy remains 0; mtlo issued during RUN -> ignored, with LO equal to the pending result.
REQ-035 SHALL cover: rst_n pulsed low at cycle 3 of a div -> HI=LO=0 and busy=0 immediately, with no done pulse afterward.
REQ-036 SHALL cover: a second mult asserted on the done cycle -> accepted, busy=1 on the next cycle, and a correct result 5 cycles later.
